// File: rtl/c2h_dma_pkg.sv
// Shared types and helpers for the C2H descriptor scheduler.
// Holds the FSM encoding, the KiB shift constant and the length-clamp helpers.
package c2h_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARB      = 2'd1,
        ST_DESC     = 2'd2,
        ST_WAIT_STS = 2'd3
    } c2h_state_e;

    localparam int unsigned KB_SHIFT  = 10;
    localparam int unsigned LEN_CMP_W = 27;

    // Each port owns an equal slice of the on-chip RAM, so its base is idx << shift.
    function automatic int unsigned port_ram_shift(input int unsigned ram_w, input int unsigned ports);
        return ram_w - int'($clog2(ports));
    endfunction

    function automatic logic [LEN_CMP_W-1:0] min_len(input logic [LEN_CMP_W-1:0] a,
                                                     input logic [LEN_CMP_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/c2h_desc_scheduler_if.sv
// Write-descriptor issue channel plus its completion-status return path.
// The scheduler drives the descriptor side as master; the DMA engine is the slave.
interface c2h_desc_scheduler_if #(
    parameter int unsigned PCIE_ADDR_WIDTH = 64,
    parameter int unsigned RAM_ADDR_WIDTH  = 14,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned TAG_WIDTH       = 8
);
    logic [PCIE_ADDR_WIDTH-1:0] desc_pcie_addr;
    logic [RAM_ADDR_WIDTH-1:0]  desc_ram_addr;
    logic [LEN_WIDTH-1:0]       desc_len;
    logic [TAG_WIDTH-1:0]       desc_tag;
    logic                       desc_valid;
    logic                       desc_ready;
    logic [TAG_WIDTH-1:0]       sts_tag;
    logic                       sts_valid;

    modport master (
        output desc_pcie_addr, desc_ram_addr, desc_len, desc_tag, desc_valid,
        input  desc_ready, sts_tag, sts_valid
    );

    modport slave (
        input  desc_pcie_addr, desc_ram_addr, desc_len, desc_tag, desc_valid,
        output desc_ready, sts_tag, sts_valid
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester at or after ptr, wrapping.
// PORTS must be a power of two so the index wraps by truncation.
module rr_arbiter #(
    parameter int unsigned PORTS = 4
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] ptr,
    output logic [PORTS-1:0]         gnt_c,
    output logic [$clog2(PORTS)-1:0] idx_c,
    output logic                     found_c
);
    localparam int unsigned IDX_W = $clog2(PORTS);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        found_c = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found_c && req[cand]) begin
                found_c = 1'b1;
                idx_c   = cand;
            end
        end
        if (found_c) gnt_c[idx_c] = 1'b1;
    end
endmodule

// File: rtl/c2h_desc_scheduler.sv
// C2H write-DMA sequencer: arbitrates port frame requests, issues one host-ring
// descriptor at a time and advances the ring slot on write-done status.
module c2h_desc_scheduler
    import c2h_dma_pkg::*;
#(
    parameter int unsigned PORTS           = 4,
    parameter int unsigned PCIE_ADDR_WIDTH = 64,
    parameter int unsigned RAM_ADDR_WIDTH  = 14,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned PCIE_RAM_NUM    = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    enable,
    input  logic [PORTS-1:0]                        enable_port,
    input  logic [PORTS-1:0]                        req_ready,
    input  logic [PORTS*LEN_WIDTH-1:0]              req_len,
    input  logic [PORTS*TAG_WIDTH-1:0]              req_tag,
    output logic [PORTS-1:0]                        grant,
    input  logic [PCIE_RAM_NUM*PCIE_ADDR_WIDTH-1:0] pcie_ram_base_addr,
    input  logic [15:0]                             pcie_buf_size_kb,
    input  logic [15:0]                             pcie_buf_cnt_max,
    c2h_desc_scheduler_if.master                    desc,
    output logic [$clog2(PCIE_RAM_NUM)-1:0]         buf_sel,
    output logic [15:0]                             buf_cnt,
    output logic                                    busy,
    output logic                                    err_oversize,
    output logic                                    err_tag
);
    localparam int unsigned IDX_W     = $clog2(PORTS);
    localparam int unsigned SEL_W     = $clog2(PCIE_RAM_NUM);
    localparam int unsigned RAM_SHIFT = port_ram_shift(RAM_ADDR_WIDTH, PORTS);

    c2h_state_e                 state;
    logic [IDX_W-1:0]           rr_ptr;
    logic [IDX_W-1:0]           port_idx;
    logic [PORTS-1:0]           port_onehot;

    logic [PORTS-1:0]           eligible_c;
    logic [PORTS-1:0]           arb_gnt_c;
    logic [IDX_W-1:0]           arb_idx_c;
    logic                       arb_found_c;
    logic [LEN_WIDTH-1:0]       sel_len_c;
    logic [TAG_WIDTH-1:0]       sel_tag_c;
    logic [PCIE_ADDR_WIDTH-1:0] sel_base_c;
    logic [31:0]                slot_prod_c;
    logic [41:0]                slot_off_c;
    logic [LEN_CMP_W-1:0]       size_bytes_c;
    logic [LEN_CMP_W-1:0]       req_len_ext_c;
    logic [15:0]                cnt_max_c;
    logic [16:0]                cnt_next_c;

    assign eligible_c = req_ready & enable_port;

    rr_arbiter #(.PORTS(PORTS)) u_arb (
        .req     (eligible_c),
        .ptr     (rr_ptr),
        .gnt_c   (arb_gnt_c),
        .idx_c   (arb_idx_c),
        .found_c (arb_found_c)
    );

    // Descriptor field datapath, evaluated against the live config during ARB.
    always_comb begin
        sel_len_c     = req_len[int'(arb_idx_c)*LEN_WIDTH +: LEN_WIDTH];
        sel_tag_c     = req_tag[int'(arb_idx_c)*TAG_WIDTH +: TAG_WIDTH];
        sel_base_c    = pcie_ram_base_addr[int'(buf_sel)*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
        slot_prod_c   = 32'(buf_cnt) * 32'(pcie_buf_size_kb);
        slot_off_c    = 42'(slot_prod_c) << KB_SHIFT;
        size_bytes_c  = LEN_CMP_W'(pcie_buf_size_kb) << KB_SHIFT;
        req_len_ext_c = LEN_CMP_W'(sel_len_c);
        cnt_max_c     = (pcie_buf_cnt_max == 16'd0) ? 16'd1 : pcie_buf_cnt_max;
        cnt_next_c    = 17'(buf_cnt) + 17'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            rr_ptr              <= '0;
            port_idx            <= '0;
            port_onehot         <= '0;
            grant               <= '0;
            buf_sel             <= '0;
            buf_cnt             <= '0;
            busy                <= 1'b0;
            err_oversize        <= 1'b0;
            err_tag             <= 1'b0;
            desc.desc_pcie_addr <= '0;
            desc.desc_ram_addr  <= '0;
            desc.desc_len       <= '0;
            desc.desc_tag       <= '0;
            desc.desc_valid     <= 1'b0;
        end else begin
            grant        <= '0;
            err_oversize <= 1'b0;
            // Stray status outside the wait window is dropped but flagged.
            err_tag      <= desc.sts_valid && (state != ST_WAIT_STS);

            unique case (state)
                ST_IDLE: begin
                    if (enable && (pcie_buf_size_kb != 16'd0) && (|eligible_c)) begin
                        state <= ST_ARB;
                        busy  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (arb_found_c) begin
                        port_idx            <= arb_idx_c;
                        port_onehot         <= arb_gnt_c;
                        desc.desc_pcie_addr <= sel_base_c + PCIE_ADDR_WIDTH'(slot_off_c);
                        desc.desc_ram_addr  <= RAM_ADDR_WIDTH'(arb_idx_c) << RAM_SHIFT;
                        desc.desc_len       <= LEN_WIDTH'(min_len(req_len_ext_c, size_bytes_c));
                        desc.desc_tag       <= sel_tag_c;
                        desc.desc_valid     <= 1'b1;
                        err_oversize        <= (req_len_ext_c > size_bytes_c);
                        state               <= ST_DESC;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_DESC: begin
                    if (desc.desc_ready) begin
                        desc.desc_valid <= 1'b0;
                        grant           <= port_onehot;
                        rr_ptr          <= port_idx + IDX_W'(1);
                        state           <= ST_WAIT_STS;
                    end
                end
                ST_WAIT_STS: begin
                    if (desc.sts_valid) begin
                        err_tag <= (desc.sts_tag != desc.desc_tag);
                        if (cnt_next_c >= 17'(cnt_max_c)) begin
                            buf_cnt <= '0;
                            buf_sel <= (buf_sel == SEL_W'(PCIE_RAM_NUM - 1)) ? '0 : buf_sel + SEL_W'(1);
                        end else begin
                            buf_cnt <= cnt_next_c[15:0];
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
